// File: rtl/pong_game_engine.sv
// pong_game_engine: frame-rate Pong state machine. It advances the ball, both paddles and the scores on a 20x15 cell grid.
//   CLK_IN       system clock
//   RST_N        asynchronous active-low reset
//   frame_tick   one-cycle pulse per video frame; all game updates happen on it
//   start        level; starts a new game from IDLE or GAMEOVER (sampled every cycle)
//   btn_up/down  player paddle controls (already synchronized and debounced)
//   ballX/ballY  ball cell (column / row)
//   playerPos    player paddle top row (column 0)
//   comPos       computer paddle top row (column W-1)
//   player_score, com_score  points per side
//   game_state   IDLE=0 SERVE=1 PLAY=2 POINT=3 GAMEOVER=4
module pong_game_engine #(
    parameter int W            = 20,
    parameter int H            = 15,
    parameter int PLAYER_SIZE  = 4,
    parameter int BALL_DIV     = 4,
    parameter int PAD_DIV      = 2,
    parameter int COM_DIV      = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       CLK_IN,
    input  logic       RST_N,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [4:0] ballX,
    output logic [3:0] ballY,
    output logic [3:0] playerPos,
    output logic [3:0] comPos,
    output logic [3:0] player_score,
    output logic [3:0] com_score,
    output logic [2:0] game_state
);
    typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, GAMEOVER = 3'd4} state_t;

    localparam logic [3:0] PMAX = 4'(H - 1 - PLAYER_SIZE);
    localparam logic [3:0] HOME = 4'((H - 1 - PLAYER_SIZE) / 2);
    localparam logic [4:0] CX   = 5'(W / 2);
    localparam logic [3:0] CY   = 4'(H / 2);
    localparam logic [3:0] SMAX = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [4:0] ball_x_q, ball_x_d;
    logic [3:0] ball_y_q, ball_y_d, player_q, player_d, com_q, com_d;
    logic [3:0] pscore_q, pscore_d, cscore_q, cscore_d;
    // dx/dy: 1 means +1, 0 means -1; sdy remembers the last serve's dy so serves alternate
    logic       dx_q, dx_d, dy_q, dy_d, sdy_q, sdy_d;
    logic [7:0] ball_cnt_q, ball_cnt_d, pad_cnt_q, pad_cnt_d, com_cnt_q, com_cnt_d, frame_cnt_q, frame_cnt_d;

    logic       ball_step, pad_step, com_step, serve_done, point_done, moving, dy_n, hit_p, hit_c;
    logic [3:0] ny;
    logic [4:0] com_c;

    assign ball_step  = ball_cnt_q == 8'(BALL_DIV - 1);
    assign pad_step   = pad_cnt_q == 8'(PAD_DIV - 1);
    assign com_step   = com_cnt_q == 8'(COM_DIV - 1);
    assign serve_done = frame_cnt_q == 8'(SERVE_FRAMES - 1);
    assign point_done = frame_cnt_q == 8'(POINT_FRAMES - 1);
    assign moving     = frame_tick && (state_q == SERVE || state_q == PLAY);
    // Vertical bounce is resolved before the step so the ball never leaves the grid
    assign dy_n  = ((ball_y_q == 4'd0 && !dy_q) || (ball_y_q == 4'(H - 1) && dy_q)) ? ~dy_q : dy_q;
    assign ny    = dy_n ? ball_y_q + 4'd1 : ball_y_q - 4'd1;
    // Hit tests use the paddle positions held before this tick's paddle update
    assign hit_p = ny >= player_q && {1'b0, ny} <= {1'b0, player_q} + 5'(PLAYER_SIZE);
    assign hit_c = ny >= com_q && {1'b0, ny} <= {1'b0, com_q} + 5'(PLAYER_SIZE);
    assign com_c = {1'b0, com_q} + 5'(PLAYER_SIZE / 2);

    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        player_d    = player_q;
        com_d       = com_q;
        pscore_d    = pscore_q;
        cscore_d    = cscore_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        sdy_d       = sdy_q;
        ball_cnt_d  = ball_cnt_q;
        pad_cnt_d   = pad_cnt_q;
        com_cnt_d   = com_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_tick) begin
            ball_cnt_d  = ball_step ? 8'd0 : ball_cnt_q + 8'd1;
            pad_cnt_d   = pad_step ? 8'd0 : pad_cnt_q + 8'd1;
            com_cnt_d   = com_step ? 8'd0 : com_cnt_q + 8'd1;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
        if (moving && pad_step) begin
            if (btn_up && !btn_down && player_q != 4'd0)
                player_d = player_q - 4'd1;
            else if (btn_down && !btn_up && player_q != PMAX)
                player_d = player_q + 4'd1;
        end
        if (moving && com_step) begin
            if ({1'b0, ball_y_q} < com_c && com_q != 4'd0)
                com_d = com_q - 4'd1;
            else if ({1'b0, ball_y_q} > com_c && com_q != PMAX)
                com_d = com_q + 4'd1;
        end
        case (state_q)
            IDLE, GAMEOVER: begin
                if (start) begin
                    state_d  = SERVE;
                    pscore_d = 4'd0;
                    cscore_d = 4'd0;
                    ball_x_d = CX;
                    ball_y_d = CY;
                    player_d = HOME;
                    com_d    = HOME;
                    dx_d     = 1'b1;
                    dy_d     = 1'b1;
                    sdy_d    = 1'b1;
                end
            end
            SERVE: state_d = (frame_tick && serve_done) ? PLAY : SERVE;
            PLAY: begin
                if (frame_tick && ball_step) begin
                    dy_d     = dy_n;
                    ball_y_d = ny;
                    ball_x_d = dx_q ? ball_x_q + 5'd1 : ball_x_q - 5'd1;
                    if (!dx_q && ball_x_q == 5'd1) begin
                        dx_d     = hit_p;
                        ball_x_d = hit_p ? 5'd2 : 5'd0;
                        cscore_d = hit_p ? cscore_q : cscore_q + 4'd1;
                        state_d  = hit_p ? PLAY : POINT;
                    end else if (dx_q && ball_x_q == 5'(W - 2)) begin
                        dx_d     = !hit_c;
                        ball_x_d = hit_c ? 5'(W - 3) : 5'(W - 1);
                        pscore_d = hit_c ? pscore_q : pscore_q + 4'd1;
                        state_d  = hit_c ? PLAY : POINT;
                    end
                end
            end
            POINT: begin
                if (frame_tick && point_done) begin
                    if (pscore_q == SMAX || cscore_q == SMAX) begin
                        state_d = GAMEOVER;
                    end else begin
                        state_d  = SERVE;
                        ball_x_d = CX;
                        ball_y_d = CY;
                        // Ball frozen in column 0 means the player conceded: serve toward the player
                        dx_d     = ball_x_q != 5'd0;
                        sdy_d    = ~sdy_q;
                        dy_d     = ~sdy_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            ball_cnt_d  = 8'd0;
            pad_cnt_d   = 8'd0;
            com_cnt_d   = 8'd0;
            frame_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            ball_x_q    <= CX;
            ball_y_q    <= CY;
            player_q    <= HOME;
            com_q       <= HOME;
            pscore_q    <= 4'd0;
            cscore_q    <= 4'd0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            sdy_q       <= 1'b1;
            ball_cnt_q  <= 8'd0;
            pad_cnt_q   <= 8'd0;
            com_cnt_q   <= 8'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            player_q    <= player_d;
            com_q       <= com_d;
            pscore_q    <= pscore_d;
            cscore_q    <= cscore_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            sdy_q       <= sdy_d;
            ball_cnt_q  <= ball_cnt_d;
            pad_cnt_q   <= pad_cnt_d;
            com_cnt_q   <= com_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign ballX        = ball_x_q;
    assign ballY        = ball_y_q;
    assign playerPos    = player_q;
    assign comPos       = com_q;
    assign player_score = pscore_q;
    assign com_score    = cscore_q;
    assign game_state   = state_q;
endmodule

// File: doc/pong_game_engine.md
Name: pong_game_engine

Overview:
Sequential game-state generator for the Pong VGA display. Advances ball, player paddle, computer paddle and scores once per video frame on the grid the renderer consumes: 20x15 cells, player paddle in column 0, computer paddle in column W-1. Its ballX/ballY/playerPos/comPos outputs feed the pixel renderer directly. Scores and state go to the score display.

Parameters:
W, 20, grid width in cells
H, 15, grid height in cells
PLAYER_SIZE, 4, a paddle covers rows pos..pos+PLAYER_SIZE (5 cells)
BALL_DIV, 4, frame ticks per ball step
PAD_DIV, 2, frame ticks per player paddle step
COM_DIV, 3, frame ticks per computer paddle step
SERVE_FRAMES, 60, frame ticks held in SERVE
POINT_FRAMES, 60, frame ticks held in POINT
WIN_SCORE, 9, score that ends the game

Ports:
CLK_IN  in  1  system clock
RST_N  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
start  in  1  level; starts a game from IDLE/GAMEOVER
btn_up  in  1  level, already synchronized and debounced
btn_down  in  1  level, already synchronized and debounced
ballX  out  5  ball column, 0..W-1
ballY  out  4  ball row, 0..H-1
playerPos  out  4  player paddle top row, 0..PMAX
comPos  out  4  computer paddle top row, 0..PMAX
player_score  out  4  player points
com_score  out  4  computer points
game_state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4

Behaviour:
- One clock: CLK_IN. Reset is asynchronous, active-low: RST_N.
- PMAX = H-1-PLAYER_SIZE (10). Centre: CX = W/2 (10), CY = H/2 (7). Paddle home = PMAX/2 (5).
- Reset: state IDLE, ballX=10, ballY=7, playerPos=comPos=5, both scores 0, dx=+1, dy=+1, all divider counters 0. Every output is a register.
- All updates occur only on a cycle where frame_tick=1, except start detection. start is sampled every cycle.
- IDLE: if start=1, go to SERVE. Scores are cleared, and the ball and paddles are centred.
- SERVE: ball held at (CX,CY). Paddles may move. After SERVE_FRAMES ticks, go to PLAY and clear the ball divider.
- PLAY:
  - Ball steps on every BALL_DIV-th tick.
  - Y first: if (ballY=0 and dy=-1) or (ballY=H-1 and dy=+1), negate dy. Then ny = ballY+dy.
  - X, moving left from ballX=1: hit if playerPos <= ny <= playerPos+PLAYER_SIZE. On hit, dx=+1 and nx=2. On miss, nx=0, com_score++, go to POINT.
  - X, moving right from ballX=W-2: same rule against comPos. On hit, dx=-1 and nx=W-3. On miss, nx=W-1, player_score++, go to POINT.
  - Otherwise nx = ballX+dx.
  - The hit test uses paddle positions before this tick's paddle update.
- POINT:
  - Ball frozen at the miss column. Paddles frozen.
  - After POINT_FRAMES ticks: if either score = WIN_SCORE, go to GAMEOVER. Otherwise go to SERVE with the ball centred.
  - Serve dx points toward the player who conceded. dy is the inverse of the previous serve's dy (toggle).
  - The first serve after reset or start has dx=+1, dy=+1.
- GAMEOVER: everything frozen and scores held. start=1 clears scores and goes to SERVE.
- Player paddle: moves in SERVE and PLAY on every PAD_DIV-th tick.
  - btn_up only: decrement if >0.
  - btn_down only: increment if <PMAX.
  - Both or neither: hold.
- Computer paddle: moves in SERVE and PLAY on every COM_DIV-th tick. Target c = comPos+PLAYER_SIZE/2.
  - ballY<c and comPos>0: decrement.
  - ballY>c and comPos<PMAX: increment.
  - Otherwise hold.
- Dividers count frame ticks modulo their DIV and restart at 0 on every state entry.
- Arithmetic: positions are unsigned. dx/dy are 1-bit direction flags. No position ever leaves its range, and scores never exceed WIN_SCORE.
- RST_N low mid-game restores reset values immediately (async). Play restarts only after start.

Test Plan:
1. Reset, start=1 for one cycle, then 60 ticks → state SERVE→PLAY, ball (10,7). After 4 more ticks, ball (11,8).
2. Hold btn_down 40 ticks in PLAY → playerPos rises by 1 every 2 ticks and saturates at 10. btn_up+btn_down together → no change.
3. Ball at (1,6) moving left/down, playerPos=5 → next step ball (2,7), dx=+1. Same with playerPos=0 → ball (0,7), com_score=1, state POINT.
4. Ball at (x,14) with dy=+1 → next step ballY=13, dy=-1. Ball at row 0 with dy=-1 → ballY=1.
5. Force com_score to 8, then a miss → POINT for 60 ticks, then GAMEOVER. start → scores 0, state SERVE.
6. Pulse RST_N low mid-PLAY asynchronously (no clock edge) → all outputs at reset values at once, state IDLE.
